// File: rtl/video_pattern_gen_axis_pp.sv
// AXI4-Stream video test-pattern source, several pixels per beat (SOLID/CHECKER/GRADIENT/COUNTER).
// Define VPG_MOVING_PATTERN_EN to offset the pattern column by frame_count so non-solid patterns scroll.
module video_pattern_gen_axis_pp #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int CHANNELS        = 3,
  parameter int PIXELS_PER_BEAT = 2,
  parameter int FRAME_WIDTH     = 1920,
  parameter int FRAME_HEIGHT    = 1080,
  parameter int LINE_GAP        = 0,
  parameter int CHECKER_LOG2    = 3
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          enable,
  input  logic [1:0]                                    pattern_sel,
  input  logic [CHANNELS*PIXEL_WIDTH-1:0]               solid_color,
  output logic                                          m_axis_tvalid,
  output logic [PIXELS_PER_BEAT*CHANNELS*PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                                          m_axis_tlast,
  output logic                                          m_axis_tuser,
  input  logic                                          m_axis_tready,
  output logic                                          frame_done,
  output logic [15:0]                                   frame_count
);

  localparam int PIX_W  = CHANNELS * PIXEL_WIDTH;
  localparam int DATA_W = PIXELS_PER_BEAT * PIX_W;
  localparam int XW     = $clog2(FRAME_WIDTH) + 1;
  localparam int YW     = $clog2(FRAME_HEIGHT) + 1;
  localparam int GAP_W  = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  // Only the low PIXEL_WIDTH bits and the checker bit of a coordinate matter.
  localparam int CW     = (PIXEL_WIDTH > CHECKER_LOG2) ? PIXEL_WIDTH : CHECKER_LOG2 + 1;

  localparam logic [XW-1:0]    X_LAST   = XW'(FRAME_WIDTH - PIXELS_PER_BEAT);
  localparam logic [XW-1:0]    X_STEP   = XW'(PIXELS_PER_BEAT);
  localparam logic [YW-1:0]    Y_LAST   = YW'(FRAME_HEIGHT - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = (LINE_GAP > 0) ? GAP_W'(LINE_GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_tvalid;
  logic                r_tlast;
  logic                r_tuser;
  logic                r_eof;
  logic [DATA_W-1:0]   r_tdata;
  logic                r_frame_done;
  logic [15:0]         r_frame_count;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [1:0]          r_pat;
  logic [PIX_W-1:0]    r_solid;

  logic                w_xfer;
  logic                w_load;
  logic                w_drop;
  logic                w_gap_start;
  logic                w_frame_end;
  logic                w_first;
  logic                w_last;
  logic                w_sof_load;
  logic [1:0]          w_pat;
  logic [PIX_W-1:0]    w_solid;
  logic [CW-1:0]       w_col_base;
  logic [CW-1:0]       w_row;
  logic [DATA_W-1:0]   w_beat;

  function automatic logic [PIX_W-1:0] f_pixel(input logic [1:0]       pat,
                                               input logic [PIX_W-1:0] solid,
                                               input logic [CW-1:0]    col,
                                               input logic [CW-1:0]    row);
    logic [PIXEL_WIDTH-1:0] chan;
    logic                   chk_bit;
    chk_bit = col[CHECKER_LOG2] ^ row[CHECKER_LOG2];
    case (pat)
      2'd1:    chan = {PIXEL_WIDTH{chk_bit}};
      2'd2:    chan = col[PIXEL_WIDTH-1:0] + row[PIXEL_WIDTH-1:0];
      2'd3:    chan = col[PIXEL_WIDTH-1:0];
      default: chan = '0;
    endcase
    return (pat == 2'd0) ? solid : {CHANNELS{chan}};
  endfunction

  assign w_xfer     = r_tvalid & m_axis_tready;
  assign w_first    = (r_x == '0) && (r_y == '0);
  assign w_last     = (r_x == X_LAST);
  assign w_sof_load = w_load & w_first;
  // The SOF beat is built from the live inputs in the same cycle they are latched.
  assign w_pat      = w_sof_load ? pattern_sel : r_pat;
  assign w_solid    = w_sof_load ? solid_color : r_solid;
  assign w_row      = CW'(r_y);

`ifdef VPG_MOVING_PATTERN_EN
  logic [15:0] w_fc_eff;
  assign w_fc_eff   = w_frame_end ? (r_frame_count + 16'd1) : r_frame_count;
  assign w_col_base = CW'(r_x) + CW'(w_fc_eff);
`else
  assign w_col_base = CW'(r_x);
`endif

  always_comb begin
    w_beat = '0;
    for (int p = 0; p < PIXELS_PER_BEAT; p++) begin
      w_beat[p*PIX_W +: PIX_W] = f_pixel(w_pat, w_solid, w_col_base + CW'(p), w_row);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_gap_start = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_load      = 1'b1;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_xfer && r_tlast) begin
          w_frame_end = r_eof;
          if (r_eof && !enable) begin
            w_drop      = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (LINE_GAP > 0) begin
            w_drop      = 1'b1;
            w_gap_start = 1'b1;
            w_state_nxt = S_GAP;
          end else begin
            w_load = 1'b1;
          end
        end else if (!r_tvalid || m_axis_tready) begin
          w_load = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_load      = 1'b1;
          w_state_nxt = S_ACTIVE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output beat register and raster position; r_x/r_y name the next beat to load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
      r_eof         <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_gap_cnt     <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_frame_count <= r_frame_count + 16'd1;

      if (w_gap_start)
        r_gap_cnt <= GAP_INIT;
      else if (r_state == S_GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);

      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_beat;
        r_tlast  <= w_last;
        r_tuser  <= w_first;
        r_eof    <= w_last && (r_y == Y_LAST);
        if (w_last) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + X_STEP;
        end
      end else if (w_drop) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  // Pattern selection is frame-granular: captured only when the SOF beat loads.
  always_ff @(posedge clk) begin
    if (w_sof_load) begin
      r_pat   <= pattern_sel;
      r_solid <= solid_color;
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign frame_done    = r_frame_done;
  assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_video_pattern_gen_axis_pp.sv
// Bench for video_pattern_gen_axis_pp: 8x4 frame, 2 pixels/beat, 2-cycle line gap, checker edge 2.
module tb_video_pattern_gen_axis_pp;

  localparam int PW  = 8;
  localparam int CH  = 3;
  localparam int PPB = 2;
  localparam int FW  = 8;
  localparam int FH  = 4;
  localparam int LG  = 2;
  localparam int CL  = 1;
  localparam int PXW = PW * CH;
  localparam int DW  = PXW * PPB;
  localparam int BPL = FW / PPB;
  localparam int BPF = BPL * FH;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic [1:0]     pattern_sel;
  logic [PXW-1:0] solid_color;
  logic           m_axis_tvalid;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tlast;
  logic           m_axis_tuser;
  logic           m_axis_tready;
  logic           frame_done;
  logic [15:0]    frame_count;

  always #5 clk = ~clk;

  video_pattern_gen_axis_pp #(
    .PIXEL_WIDTH(PW), .CHANNELS(CH), .PIXELS_PER_BEAT(PPB), .FRAME_WIDTH(FW),
    .FRAME_HEIGHT(FH), .LINE_GAP(LG), .CHECKER_LOG2(CL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  int checks = 0;
  int errors = 0;

  logic [DW+1:0] cap_q[$];
  logic [DW+1:0] exp_q[$];
  int            gap_q[$];
  logic          gapuser_q[$];
  int            done_d_q[$];
  int            done_cnt = 0;
  int            hold_n = 0;
  int            hold_bad = 0;
  int            cyc = 0;
  int            last_tlast_cyc = 0;
  int            gap_len = 0;
  logic          in_gap = 1'b0;
  logic          prev_hold = 1'b0;
  logic [DW+1:0] prev_beat = '0;

  // Passive observer, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      prev_hold <= 1'b0;
      in_gap    <= 1'b0;
    end else begin
      if (prev_hold) begin
        hold_n <= hold_n + 1;
        if (!(m_axis_tvalid && {m_axis_tuser, m_axis_tlast, m_axis_tdata} == prev_beat))
          hold_bad <= hold_bad + 1;
      end
      prev_hold <= m_axis_tvalid && !m_axis_tready;
      prev_beat <= {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        done_d_q.push_back(cyc - last_tlast_cyc);
      end
      if (in_gap) begin
        if (m_axis_tvalid) begin
          gap_q.push_back(gap_len);
          gapuser_q.push_back(m_axis_tuser);
          in_gap <= 1'b0;
        end else begin
          gap_len <= gap_len + 1;
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (m_axis_tlast) begin
          in_gap         <= 1'b1;
          gap_len        <= 0;
          last_tlast_cyc <= cyc;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference pixel rules written directly from the pattern definitions.
  function automatic logic [DW-1:0] exp_beat(input int pat, input logic [PXW-1:0] solid,
                                             input int b, input int row);
    logic [DW-1:0]  d;
    logic [PXW-1:0] px;
    int             col;
    int             v;
    d = '0;
    for (int p = 0; p < PPB; p++) begin
      col = b * PPB + p;
      px  = '0;
      if (pat == 0) begin
        px = solid;
      end else begin
        if (pat == 1)      v = ((((col / (1 << CL)) + (row / (1 << CL))) % 2) == 1) ? (1 << PW) - 1 : 0;
        else if (pat == 2) v = (col + row) % (1 << PW);
        else               v = col % (1 << PW);
        for (int c = 0; c < CH; c++) px[c*PW +: PW] = PW'(v);
      end
      d[p*PXW +: PXW] = px;
    end
    return d;
  endfunction

  task automatic push_frame(input int pat, input logic [PXW-1:0] solid);
    for (int y = 0; y < FH; y++)
      for (int b = 0; b < BPL; b++)
        exp_q.push_back({(y == 0 && b == 0), (b == BPL - 1), exp_beat(pat, solid, b, y)});
  endtask

  task automatic compare_frames(input string tag);
    chk({tag, "_beat_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int tgt, input int budget);
    for (int i = 0; i < budget && done_cnt < tgt; i++) step();
    chk("frame_done_seen", 64'(done_cnt), 64'(tgt));
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && cap_q.size() < n; i++) step();
    chk("beats_reached", 64'(cap_q.size() >= n), 64'd1);
  endtask

  task automatic start_frame(input int pat, input logic [PXW-1:0] solid);
    pattern_sel = 2'(pat);
    solid_color = solid;
    enable      = 1'b1;
    step();
    enable      = 1'b0;
  endtask

  initial begin
    int             tgt;
    int             p1, p2, p6;
    logic [PXW-1:0] s1, s2, s6;

    reset_n       = 1'b0;
    enable        = 1'b0;
    m_axis_tready = 1'b1;
    pattern_sel   = 2'd0;
    solid_color   = '0;
    tgt           = 0;
    repeat (3) step();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata",  64'(m_axis_tdata),  64'd0);
    chk("rst_tlast",  64'(m_axis_tlast),  64'd0);
    chk("rst_tuser",  64'(m_axis_tuser),  64'd0);
    chk("rst_done",   64'(frame_done),    64'd0);
    chk("rst_fcount", 64'(frame_count),   64'd0);
    reset_n = 1'b1;
    step();

    // SOLID single frame, then idle
    start_frame(0, 24'h123456);
    push_frame(0, 24'h123456);
    tgt++;
    wait_done(tgt, 200);
    repeat (4) step();
    chk("solid_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("solid_fcount", 64'(frame_count), 64'd1);
    chk("solid_beat0", 64'(cap_q[0][DW-1:0]), 64'h123456123456);
    compare_frames("solid");

    // GRADIENT with a 5-cycle stall on beat 5
    start_frame(2, PXW'($urandom));
    wait_beats(5, 100);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("stall_tdata", 64'(m_axis_tdata), 64'h040404030303);
      step();
    end
    m_axis_tready = 1'b1;
    push_frame(2, '0);
    tgt++;
    wait_done(tgt, 200);
    compare_frames("grad_stall");

    // Random patterns under random backpressure, inputs scrambled mid-frame
    for (int f = 0; f < 3; f++) begin
      p1 = int'($urandom_range(0, 3));
      s1 = PXW'($urandom);
      start_frame(p1, s1);
      pattern_sel = 2'($urandom_range(0, 3));
      solid_color = PXW'($urandom);
      push_frame(p1, s1);
      tgt++;
      for (int i = 0; i < 600 && done_cnt < tgt; i++) begin
        m_axis_tready = 1'($urandom_range(0, 1));
        step();
      end
      m_axis_tready = 1'b1;
      chk("rand_done", 64'(done_cnt), 64'(tgt));
      compare_frames($sformatf("rand%0d", f));
    end

    // Back-to-back frames relatching at SOF, enable dropped mid second frame
    p1 = int'($urandom_range(0, 2));
    s1 = PXW'($urandom);
    p2 = int'($urandom_range(0, 2));
    s2 = PXW'($urandom);
    pattern_sel = 2'(p1);
    solid_color = s1;
    enable      = 1'b1;
    step();
    wait_beats(6, 100);
    pattern_sel = 2'(p2);
    solid_color = s2;
    wait_beats(BPF + 6, 200);
    enable      = 1'b0;
    pattern_sel = 2'd3;
    solid_color = PXW'($urandom);
    push_frame(p1, s1);
    push_frame(p2, s2);
    tgt += 2;
    wait_done(tgt, 400);
    repeat (4) step();
    chk("cont_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    compare_frames("cont");

    // Re-enable picks up COUNTER at the new SOF
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("counter_sof_tuser", 64'(m_axis_tuser), 64'd1);
    chk("counter_sof_tdata", 64'(m_axis_tdata), 64'h010101000000);
    push_frame(3, '0);
    tgt++;
    wait_done(tgt, 200);
    compare_frames("counter");

    // CHECKER landmarks
    start_frame(1, PXW'($urandom));
    push_frame(1, '0);
    tgt++;
    wait_done(tgt, 200);
    chk("chk_b0", 64'(cap_q[0][DW-1:0]), 64'h0);
    chk("chk_b1", 64'(cap_q[1][DW-1:0]), 64'hFFFFFFFFFFFF);
    chk("chk_y2_b0", 64'(cap_q[8][DW-1:0]), 64'hFFFFFFFFFFFF);
    compare_frames("checker");
    chk("fcount_pre_reset", 64'(frame_count), 64'(tgt));

    // Asynchronous reset in the middle of line 2
    start_frame(int'($urandom_range(0, 3)), PXW'($urandom));
    wait_beats(9, 100);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_tdata",  64'(m_axis_tdata),  64'd0);
    chk("mid_rst_tlast",  64'(m_axis_tlast),  64'd0);
    chk("mid_rst_tuser",  64'(m_axis_tuser),  64'd0);
    chk("mid_rst_done",   64'(frame_done),    64'd0);
    chk("mid_rst_fcount", 64'(frame_count),   64'd0);
    step();
    step();
    reset_n = 1'b1;
    cap_q.delete();
    step();
    p6 = int'($urandom_range(0, 3));
    s6 = PXW'($urandom);
    start_frame(p6, s6);
    chk("restart_tuser", 64'(m_axis_tuser), 64'd1);
    chk("restart_tdata", 64'(m_axis_tdata), 64'(exp_beat(p6, s6, 0, 0)));
    push_frame(p6, s6);
    tgt++;
    wait_done(tgt, 200);
    chk("restart_fcount", 64'(frame_count), 64'd1);
    compare_frames("restart");

    // Line gaps, done latency and stall stability gathered by the observer
    chk("gap_entries", 64'(gap_q.size() >= 20), 64'd1);
    foreach (gap_q[i]) if (!gapuser_q[i]) chk($sformatf("line_gap%0d", i), 64'(gap_q[i]), 64'(LG));
    foreach (done_d_q[i]) chk($sformatf("done_latency%0d", i), 64'(done_d_q[i]), 64'd1);
    chk("hold_seen", 64'(hold_n >= 5), 64'd1);
    chk("hold_stable", 64'(hold_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
